// File: rtl/nf10_rtr_defs_pkg.sv
// Shared router definitions: word-position encoding and default widths.
// Included by the ingress tracker and the header parsers.
package nf10_rtr_defs;

   typedef enum logic [1:0] {
      WORD1   = 2'd0,
      WORD2   = 2'd1,
      PAYLOAD = 2'd2
   } word_state_e;

   localparam int SRC_PORT_POS = 16;

   localparam int DEF_TDATA_WIDTH        = 256;
   localparam int DEF_TUSER_WIDTH        = 128;
   localparam int DEF_DATA_DEPTH_BITS    = 5;
   localparam int DEF_MAX_PKTS_IN_FLIGHT = 3;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: head entry is visible on dout
// the cycle after it is written.
module fallthrough_small_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             nearly_full,
   output logic             empty
);

   localparam int DEPTH = 1 << MAX_DEPTH_BITS;
   localparam logic [MAX_DEPTH_BITS:0] DEPTH_W = (MAX_DEPTH_BITS+1)'(DEPTH);
   localparam logic [MAX_DEPTH_BITS:0] NF_W    = (MAX_DEPTH_BITS+1)'(DEPTH - 1);
   localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE = MAX_DEPTH_BITS'(1);
   localparam logic [MAX_DEPTH_BITS:0] CNT_ONE = (MAX_DEPTH_BITS+1)'(1);

   logic [WIDTH-1:0]          mem_q [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [MAX_DEPTH_BITS:0]   depth_q, depth_d;
   logic                      do_wr, do_rd;

   always_comb begin
      do_rd    = rd_en & (depth_q != '0);
      do_wr    = wr_en & (depth_q != DEPTH_W);
      wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      unique case ({do_wr, do_rd})
         2'b10:   depth_d = depth_q + CNT_ONE;
         2'b01:   depth_d = depth_q - CNT_ONE;
         default: depth_d = depth_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         depth_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         depth_q  <= depth_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= din;
   end

   assign dout        = mem_q[rd_ptr_q];
   assign empty       = (depth_q == '0);
   assign nearly_full = (depth_q >= NF_W);

endmodule

// File: rtl/pkt_word_tracker.sv
// Ingress stage: buffers beats, strobes header words 1/2 to the parsers,
// and stalls new packets while too many header results are outstanding.
module pkt_word_tracker
   import nf10_rtr_defs::*;
#(
   parameter int C_S_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
   parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
   parameter int DATA_DEPTH_BITS      = DEF_DATA_DEPTH_BITS,
   parameter int MAX_PKTS_IN_FLIGHT   = DEF_MAX_PKTS_IN_FLIGHT
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [C_S_AXIS_TDATA_WIDTH-1:0]   o_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   o_tuser,
   output logic                              o_pkt_word1,
   output logic                              o_pkt_word2,
   output logic                              o_pkt_short,
   input  logic                              i_hdr_rd,
   output logic [C_S_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tlast,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic [1:0]                        o_pkts_in_flight
);

   localparam int KEEP_W = C_S_AXIS_TDATA_WIDTH / 8;
   localparam int FIFO_W = C_S_AXIS_TDATA_WIDTH + KEEP_W + C_S_AXIS_TUSER_WIDTH + 1;
   localparam logic [1:0] MAX_INF = 2'(MAX_PKTS_IN_FLIGHT);

   word_state_e state_q, state_d;
   logic [1:0]  in_flight_q, in_flight_d;
   logic        reset_q;
   logic        word1_q, word1_d;
   logic        word2_q, word2_d;
   logic        short_q, short_d;
   logic [C_S_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;

   logic              acc, inc, dec;
   logic              buf_nearly_full, buf_empty;
   logic [FIFO_W-1:0] buf_din, buf_dout;

   // New packets wait at the boundary; a started packet always drains.
   assign s_axis_tready = !reset & !reset_q & !buf_nearly_full
                        & !((state_q == WORD1) & (in_flight_q == MAX_INF));
   assign acc = s_axis_tvalid & s_axis_tready;

   always_comb begin
      state_d = state_q;
      if (acc) begin
         case (state_q)
            WORD1:   state_d = s_axis_tlast ? WORD1 : WORD2;
            WORD2:   state_d = s_axis_tlast ? WORD1 : PAYLOAD;
            default: state_d = s_axis_tlast ? WORD1 : PAYLOAD;
         endcase
      end
   end

   always_comb begin
      word1_d = acc & (state_q == WORD1);
      word2_d = acc & (state_q == WORD2);
      short_d = word1_d & s_axis_tlast;
      tdata_d = acc ? s_axis_tdata : tdata_q;
      tuser_d = acc ? s_axis_tuser : tuser_q;
      inc     = acc & (state_q == WORD1);
      dec     = i_hdr_rd & (in_flight_q != 2'd0);
      unique case ({inc, dec})
         2'b10:   in_flight_d = in_flight_q + 2'd1;
         2'b01:   in_flight_d = in_flight_q - 2'd1;
         default: in_flight_d = in_flight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      reset_q <= reset;
      if (reset) begin
         state_q     <= WORD1;
         in_flight_q <= 2'd0;
         word1_q     <= 1'b0;
         word2_q     <= 1'b0;
         short_q     <= 1'b0;
         tdata_q     <= '0;
         tuser_q     <= '0;
      end else begin
         state_q     <= state_d;
         in_flight_q <= in_flight_d;
         word1_q     <= word1_d;
         word2_q     <= word2_d;
         short_q     <= short_d;
         tdata_q     <= tdata_d;
         tuser_q     <= tuser_d;
      end
   end

   assign buf_din = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

   fallthrough_small_fifo #(
      .WIDTH          (FIFO_W),
      .MAX_DEPTH_BITS (DATA_DEPTH_BITS)
   ) u_beat_buf (
      .clk         (clk),
      .reset       (reset),
      .din         (buf_din),
      .wr_en       (acc),
      .rd_en       (m_axis_tready),
      .dout        (buf_dout),
      .nearly_full (buf_nearly_full),
      .empty       (buf_empty)
   );

   assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = buf_dout;
   assign m_axis_tvalid    = !buf_empty;
   assign o_tdata          = tdata_q;
   assign o_tuser          = tuser_q;
   assign o_pkt_word1      = word1_q;
   assign o_pkt_word2      = word2_q;
   assign o_pkt_short      = short_q;
   assign o_pkts_in_flight = in_flight_q;

endmodule

// File: tb/tb_pkt_word_tracker.sv
// Randomized scoreboard bench for pkt_word_tracker against a
// packet-position / occupancy reference model.
module tb_pkt_word_tracker;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [255:0] s_axis_tdata = '0;
   logic [31:0]  s_axis_tkeep = '0;
   logic [127:0] s_axis_tuser = '0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tlast = 1'b0;
   logic         s_axis_tready;
   logic [255:0] o_tdata;
   logic [127:0] o_tuser;
   logic         o_pkt_word1, o_pkt_word2, o_pkt_short;
   logic         i_hdr_rd = 1'b0;
   logic [255:0] m_axis_tdata;
   logic [31:0]  m_axis_tkeep;
   logic [127:0] m_axis_tuser;
   logic         m_axis_tlast, m_axis_tvalid;
   logic         m_axis_tready = 1'b0;
   logic [1:0]   o_pkts_in_flight;

   pkt_word_tracker dut (
      .clk              (clk),
      .reset            (reset),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tkeep     (s_axis_tkeep),
      .s_axis_tuser     (s_axis_tuser),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tlast     (s_axis_tlast),
      .s_axis_tready    (s_axis_tready),
      .o_tdata          (o_tdata),
      .o_tuser          (o_tuser),
      .o_pkt_word1      (o_pkt_word1),
      .o_pkt_word2      (o_pkt_word2),
      .o_pkt_short      (o_pkt_short),
      .i_hdr_rd         (i_hdr_rd),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tkeep     (m_axis_tkeep),
      .m_axis_tuser     (m_axis_tuser),
      .m_axis_tlast     (m_axis_tlast),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .o_pkts_in_flight (o_pkts_in_flight)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         last;
      logic [127:0] u;
      logic [31:0]  k;
      logic [255:0] d;
   } beat_t;

   typedef struct {
      int           cyc;
      logic         w1;
      logic         w2;
      logic         sh;
      logic [255:0] d;
      logic [127:0] u;
   } hdr_t;

   beat_t q_m[$];
   hdr_t  q_h[$];
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   bit    done = 0;

   task automatic chk(input string nm, input logic [511:0] act,
                      input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   // Stimulus plus model of packet position, occupancy and in-flight count.
   initial begin
      int    pos = 0;
      int    inflight = 0;
      bit    prev_rst = 1;
      bit    rst_done = 0;
      int    rst_cnt = 0;
      bit    acc, exp_rdy;
      beat_t b;
      hdr_t  h;
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         cyc++;
         reset = (cyc <= 4);
         if (cyc >= 480 && cyc < 600 && !rst_done && pos == 2) begin
            rst_done = 1;
            rst_cnt = 2;
         end
         if (rst_cnt > 0) begin
            reset = 1;
            rst_cnt--;
         end
         for (int i = 0; i < 8; i++) s_axis_tdata[i*32 +: 32] = $urandom();
         for (int i = 0; i < 4; i++) s_axis_tuser[i*32 +: 32] = $urandom();
         s_axis_tkeep  = $urandom();
         s_axis_tvalid = ($urandom_range(0, 3) != 0);
         s_axis_tlast  = ($urandom_range(0, 2) == 0);
         m_axis_tready = ($urandom_range(0, 3) != 0);
         i_hdr_rd      = ($urandom_range(0, 3) == 0);
         if (cyc >= 300 && cyc < 400) begin
            m_axis_tready = 1;
            s_axis_tlast  = ($urandom_range(0, 1) == 0);
            i_hdr_rd      = ($urandom_range(0, 15) == 0);
         end else if (cyc >= 400 && cyc < 480) begin
            m_axis_tready = 0;
            s_axis_tvalid = 1;
            s_axis_tlast  = ($urandom_range(0, 7) == 0);
            i_hdr_rd      = ($urandom_range(0, 1) == 0);
         end else if (cyc >= 600 && cyc < 700) begin
            s_axis_tlast  = 1;
            i_hdr_rd      = ($urandom_range(0, 1) == 0);
         end else if (cyc >= 700) begin
            s_axis_tvalid = 0;
            m_axis_tready = 1;
            i_hdr_rd      = 1;
         end
         if (reset) begin
            m_axis_tready = 0;
            i_hdr_rd = 0;
         end
         #1;
         exp_rdy = !reset && !prev_rst && q_m.size() < 31
                   && !(pos == 0 && inflight == 3);
         chk("s_axis_tready", 512'(s_axis_tready), 512'(exp_rdy));
         chk("m_axis_tvalid", 512'(m_axis_tvalid), 512'(q_m.size() > 0));
         chk("pkts_in_flight", 512'(o_pkts_in_flight), 512'(inflight));
         if (prev_rst) begin
            chk("rst_o_tdata", 512'(o_tdata), 512'(0));
            chk("rst_o_tuser", 512'(o_tuser), 512'(0));
         end
         acc = s_axis_tvalid && s_axis_tready;
         if (acc) begin
            b.last = s_axis_tlast;
            b.u = s_axis_tuser;
            b.k = s_axis_tkeep;
            b.d = s_axis_tdata;
            q_m.push_back(b);
            h.cyc = cyc;
            h.w1 = (pos == 0);
            h.w2 = (pos == 1);
            h.sh = (pos == 0) && s_axis_tlast;
            h.d = s_axis_tdata;
            h.u = s_axis_tuser;
            q_h.push_back(h);
         end
         if (acc && pos == 0) inflight++;
         if (i_hdr_rd && inflight > 0 && !(acc && pos == 0)) inflight--;
         else if (i_hdr_rd && acc && pos == 0 && inflight > 1) inflight--;
         if (acc) pos = s_axis_tlast ? 0 : (pos < 2 ? pos + 1 : 2);
         if (reset) begin
            q_m.delete();
            inflight = 0;
            pos = 0;
         end
         prev_rst = reset;
      end
      @(negedge clk);
      #3;
      chk("drain_m_queue", 512'(q_m.size()), 512'(0));
      chk("drain_hdr_queue", 512'(q_h.size()), 512'(0));
      chk("rst_pulse_hit", 512'(rst_done), 512'(1));
      done = 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Forwarding-path monitor: every popped beat must match the next accepted one.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!done && m_axis_tvalid === 1'b1 && m_axis_tready) begin
            if (q_m.size() == 0) begin
               chk("m_axis_unexpected", 512'(1), 512'(0));
            end else begin
               e = q_m.pop_front();
               chk("m_axis_tdata", 512'(m_axis_tdata), 512'(e.d));
               chk("m_axis_tkeep", 512'(m_axis_tkeep), 512'(e.k));
               chk("m_axis_tuser", 512'(m_axis_tuser), 512'(e.u));
               chk("m_axis_tlast", 512'(m_axis_tlast), 512'(e.last));
            end
         end
      end
   end

   // Header-side monitor: strobes and registered copy one cycle after acceptance.
   initial begin
      hdr_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!done && cyc > 1) begin
            if (q_h.size() > 0 && q_h[0].cyc == cyc - 1) begin
               e = q_h.pop_front();
               chk("o_pkt_word1", 512'(o_pkt_word1), 512'(e.w1));
               chk("o_pkt_word2", 512'(o_pkt_word2), 512'(e.w2));
               chk("o_pkt_short", 512'(o_pkt_short), 512'(e.sh));
               chk("o_tdata", 512'(o_tdata), 512'(e.d));
               chk("o_tuser", 512'(o_tuser), 512'(e.u));
            end else begin
               chk("strobes_idle", 512'({o_pkt_word1, o_pkt_word2, o_pkt_short}),
                   512'(0));
            end
         end
      end
   end

endmodule
